// File: rtl/arc4_phase_sched.sv
// ARC4 phase sequencer: runs init -> ksa -> prga on one start request,
// owns the shared S-memory port and aborts a stuck phase via a watchdog.
module arc4_phase_sched #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_INIT_RUN,
        S_KSA_REQ,
        S_KSA_RUN,
        S_PRGA_REQ,
        S_PRGA_RUN
    } state_t;

    state_t          state, state_n;
    logic            err_n;
    logic            busy_seen, busy_seen_n;
    logic [WD_W-1:0] wdog, wdog_n, wdog_inc;
    logic            sel_rdy, is_req, is_run, done, timeout;

    // State register; reset aborts any phase without touching the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            err       <= 1'b0;
            busy_seen <= 1'b0;
            wdog      <= '0;
        end else begin
            state     <= state_n;
            err       <= err_n;
            busy_seen <= busy_seen_n;
            wdog      <= wdog_n;
        end
    end

    // Next-state, handshake pulses, watchdog and phase decode.
    always_comb begin
        state_n     = state;
        err_n       = err;
        busy_seen_n = busy_seen;
        wdog_n      = wdog;
        phase       = 2'd0;
        is_req      = 1'b0;
        is_run      = 1'b0;
        init_en     = 1'b0;
        ksa_en      = 1'b0;
        prga_en     = 1'b0;

        unique case (state)
            S_INIT_REQ: begin phase = 2'd1; is_req = 1'b1; init_en = init_rdy; end
            S_INIT_RUN: begin phase = 2'd1; is_run = 1'b1; end
            S_KSA_REQ:  begin phase = 2'd2; is_req = 1'b1; ksa_en  = ksa_rdy;  end
            S_KSA_RUN:  begin phase = 2'd2; is_run = 1'b1; end
            S_PRGA_REQ: begin phase = 2'd3; is_req = 1'b1; prga_en = prga_rdy; end
            S_PRGA_RUN: begin phase = 2'd3; is_run = 1'b1; end
            default:    phase = 2'd0;
        endcase

        rdy = (state == S_IDLE);

        unique case (phase)
            2'd1:    sel_rdy = init_rdy;
            2'd2:    sel_rdy = ksa_rdy;
            2'd3:    sel_rdy = prga_rdy;
            default: sel_rdy = 1'b0;
        endcase

        // A stage must be seen busy before its rdy counts as completion.
        done     = is_run && busy_seen && sel_rdy;
        timeout  = (is_req || is_run) && (wdog == WD_LAST) && !done;
        wdog_inc = (wdog == '1) ? wdog : wdog + 1'b1;

        if (state == S_IDLE) begin
            if (en) begin
                state_n = S_INIT_REQ;
                err_n   = 1'b0;
            end
        end else if (done) begin
            wdog_n = wdog_inc;
            unique case (state)
                S_INIT_RUN: state_n = S_KSA_REQ;
                S_KSA_RUN:  state_n = S_PRGA_REQ;
                default:    state_n = S_IDLE;
            endcase
        end else if (timeout) begin
            wdog_n  = wdog_inc;
            err_n   = 1'b1;
            state_n = S_IDLE;
        end else begin
            wdog_n = wdog_inc;
            if (is_req && sel_rdy) begin
                busy_seen_n = 1'b0;
                unique case (state)
                    S_INIT_REQ: state_n = S_INIT_RUN;
                    S_KSA_REQ:  state_n = S_KSA_RUN;
                    default:    state_n = S_PRGA_RUN;
                endcase
            end else if (is_run && !sel_rdy) begin
                busy_seen_n = 1'b1;
            end
        end

        // Every phase gets a fresh watchdog budget covering REQ and RUN.
        if (state_n != state &&
            (state_n == S_INIT_REQ || state_n == S_KSA_REQ || state_n == S_PRGA_REQ))
            wdog_n = '0;
    end

    // Shared S-memory port follows the active phase; idle drives zeros.
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        unique case (phase)
            2'd1: begin s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren; end
            2'd2: begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;  end
            2'd3: begin s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arc4_phase_sched.sv
// Bench for arc4_phase_sched: stage models with programmable busy lengths,
// a phase-level reference model checked every cycle, and scenario tasks.
module tb_arc4_phase_sched;

    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy, err;
    logic [1:0] phase;
    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_cnt = 0;
    int mon_fail = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    arc4_phase_sched #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .err(err), .phase(phase),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    // ---------------- stage models ----------------
    // rdy drops the cycle after en and returns len cycles later.
    int         cnt[3] = '{0, 0, 0};
    int         len[3] = '{1, 1, 1};
    bit         hold[3] = '{0, 0, 0};
    bit         kill = 1'b0;
    bit         rnd_wren = 1'b0;
    logic [7:0] wd[3];
    logic       wr[3];
    logic [2:0] sen, srdy;

    assign sen = {prga_en, ksa_en, init_en};
    assign init_rdy = (cnt[0] == 0) && !hold[0];
    assign ksa_rdy  = (cnt[1] == 0) && !hold[1];
    assign prga_rdy = (cnt[2] == 0) && !hold[2];
    assign srdy = {prga_rdy, ksa_rdy, init_rdy};
    assign init_addr = 8'(cnt[0]);
    assign ksa_addr  = 8'hA5;
    assign prga_addr = 8'h3C;
    assign init_wrdata = wd[0];
    assign ksa_wrdata  = wd[1];
    assign prga_wrdata = wd[2];
    assign init_wren = wr[0];
    assign ksa_wren  = wr[1];
    assign prga_wren = wr[2];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (kill) cnt[k] <= 0;
            else if (sen[k]) cnt[k] <= len[k];
            else if (cnt[k] > 0) cnt[k] <= cnt[k] - 1;
            wd[k] <= 8'($urandom);
            wr[k] <= rnd_wren ? 1'($urandom) : 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // Tracks which phase is active, whether its stage has been started,
    // whether it has been seen busy, and how long the phase has lasted.
    int m_ph = 0;
    int m_age = 0;
    bit m_run = 0, m_busy = 0, m_err = 0, m_r;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_run = 0; m_busy = 0; m_err = 0; m_age = 0;
        end else if (m_ph == 0) begin
            if (en) begin m_ph = 1; m_run = 0; m_age = 0; m_err = 0; end
        end else begin
            m_r = srdy[m_ph-1];
            if (m_run && m_busy && m_r) begin
                m_ph  = (m_ph == 3) ? 0 : m_ph + 1;
                m_run = 0;
                m_age = 0;
            end else if (m_age == TO - 1) begin
                m_err = 1; m_ph = 0;
            end else begin
                m_age++;
                if (!m_run) begin
                    if (m_r) begin m_run = 1; m_busy = 0; end
                end else if (!m_r) m_busy = 1;
            end
        end
    end

    logic [23:0] obs_v, exp_v;
    logic [7:0]  e_addr, e_wd;
    logic        e_wr;
    logic [2:0]  e_en;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (mon_on) begin
            e_addr = 8'h00; e_wd = 8'h00; e_wr = 1'b0;
            for (int k = 0; k < 3; k++) e_en[k] = (m_ph == k + 1) && !m_run && srdy[k];
            if (m_ph >= 1) begin
                e_addr = (m_ph == 1) ? init_addr : (m_ph == 2) ? 8'hA5 : 8'h3C;
                e_wd   = wd[m_ph-1];
                e_wr   = wr[m_ph-1];
            end
            exp_v = {(m_ph == 0), m_err, 2'(m_ph), e_en, e_addr, e_wd, e_wr};
            obs_v = {rdy, err, phase, prga_en, ksa_en, init_en, s_addr, s_wrdata, s_wren};
            mon_cnt++;
            if (obs_v !== exp_v) begin
                mon_fail++;
                if (mon_fail <= 10)
                    $display("FAIL model_cycle t=%0t got=%h want=%h", $time, obs_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_en();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int bound, input string nm);
        int i = 0;
        while (phase !== 2'(p) && i < bound) begin @(negedge clk); i++; end
        n_tests++;
        if (phase !== 2'(p)) begin
            n_fail++;
            $display("FAIL %s_wait_phase got=%0d want=%0d", nm, phase, p);
        end
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int i = 0;
        while (rdy !== 1'b1 && i < bound) begin @(negedge clk); i++; end
        n_tests++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_idle got rdy=%b want 1", nm, rdy);
        end
    endtask

    task automatic set_len(input int a, input int b, input int c);
        len[0] = a; len[1] = b; len[2] = c;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rdy, err, phase, init_en, ksa_en, prga_en, s_wren} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset got=%b want=10000000",
                     {rdy, err, phase, init_en, ksa_en, prga_en, s_wren});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_happy();
        int cnt_en[3] = '{0, 0, 0};
        int ord[$];
        int phs[$];
        int last = 0;
        int i = 0;
        set_len(256, 768, 40);
        pulse_en();
        while (i < 3000 && !(rdy === 1'b1 && i > 0)) begin
            for (int k = 0; k < 3; k++) if (sen[k] === 1'b1) begin cnt_en[k]++; ord.push_back(k); end
            if (int'(phase) != last) begin last = int'(phase); phs.push_back(last); end
            @(negedge clk); i++;
        end
        if (int'(phase) != last) phs.push_back(int'(phase));
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (cnt_en[k] != 1) begin
                n_fail++;
                $display("FAIL happy_en_count stage=%0d got=%0d want=1", k, cnt_en[k]);
            end
        end
        n_tests++;
        if (ord.size() != 3 || ord[0] != 0 || ord[1] != 1 || ord[2] != 2) begin
            n_fail++;
            $display("FAIL happy_en_order got=%p want 0,1,2", ord);
        end
        n_tests++;
        if (phs.size() != 4 || phs[0] != 1 || phs[1] != 2 || phs[2] != 3 || phs[3] != 0) begin
            n_fail++;
            $display("FAIL happy_phase_seq got=%p want 1,2,3,0", phs);
        end
        n_tests++;
        if (rdy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL happy_end got rdy=%b err=%b want rdy=1 err=0", rdy, err);
        end
    endtask

    task automatic test_mux();
        int bad = 0;
        set_len(20, 30, 20);
        repeat (3) begin @(negedge clk); if (s_wren !== 1'b0 || s_addr !== 8'h00) bad++; end
        pulse_en();
        for (int i = 0; i < 200; i++) begin
            case (phase)
                2'd1: if (s_addr !== init_addr || s_wren !== 1'b1) bad++;
                2'd2: if (s_addr !== 8'hA5 || s_wren !== 1'b1) bad++;
                2'd3: if (s_addr !== 8'h3C || s_wren !== 1'b1) bad++;
                default: if (s_addr !== 8'h00 || s_wren !== 1'b0) bad++;
            endcase
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mux_track got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        set_len(10, 20, 10);
        hold[1] = 1'b1;
        pulse_en();
        wait_phase(2, 200, "stall");
        for (int i = 0; i < 50; i++) begin
            if (ksa_en !== 1'b0 || phase !== 2'd2) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        hold[1] = 1'b0;
        #1;
        n_tests++;
        if (ksa_en !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got ksa_en=%b want 1", ksa_en);
        end
        wait_idle(500, "stall");
    endtask

    task automatic test_watchdog();
        int k = 0;
        set_len(5, 5, 100000);
        pulse_en();
        wait_phase(3, 200, "wdog");
        while (phase !== 2'd0 && k < TO + 10) begin @(negedge clk); k++; end
        n_tests++;
        if (k != TO) begin
            n_fail++;
            $display("FAIL wdog_latency got=%0d want=%0d", k, TO);
        end
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_err got=%b want 1", err);
        end
        kill = 1'b1; @(negedge clk); kill = 1'b0;
        set_len(5, 5, 5);
        pulse_en();
        n_tests++;
        if (err !== 1'b0 || phase !== 2'd1) begin
            n_fail++;
            $display("FAIL wdog_clear got err=%b phase=%0d want err=0 phase=1", err, phase);
        end
        wait_idle(200, "wdog");
    endtask

    task automatic test_boundary(input int plen, input bit want_err);
        set_len(5, 5, plen);
        pulse_en();
        wait_idle(TO + 200, "boundary");
        n_tests++;
        if (err !== want_err) begin
            n_fail++;
            $display("FAIL boundary_len%0d got err=%b want %b", plen, err, want_err);
        end
        kill = 1'b1; @(negedge clk); kill = 1'b0;
    endtask

    task automatic test_rst_mid();
        set_len(10, 200, 10);
        pulse_en();
        wait_phase(2, 100, "rstmid");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rdy, phase, s_wren, ksa_en} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rstmid_abort got=%b want=10000", {rdy, phase, s_wren, ksa_en});
        end
        rst = 1'b0;
        pulse_en();
        n_tests++;
        if (phase !== 2'd1 || init_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_restart got phase=%0d init_en=%b want 1,1", phase, init_en);
        end
        wait_idle(1000, "rstmid");
    endtask

    task automatic test_random();
        rnd_wren = 1'b1;
        for (int r = 0; r < 6; r++) begin
            set_len($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40));
            for (int i = 0; i < 400; i++) begin
                en = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            en = 1'b0;
            wait_idle(300, "random");
        end
        rnd_wren = 1'b0;
    endtask

    initial begin
        test_reset();
        mon_on = 1'b1;
        test_happy();
        test_mux();
        test_stall();
        test_watchdog();
        test_boundary(TO - 2, 1'b0);
        test_boundary(TO - 1, 1'b1);
        test_rst_mid();
        test_random();
        test_reset();
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        n_tests += mon_cnt;
        n_fail  += mon_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
